// File: rtl/timer_dev.sv
// Programmable down-counting bus timer with one-shot/auto-reload modes and a maskable IRQ.
// Optional prescaler on CTRL[8+PS_W-1:8] is built only when TIMER_PRESCALE_EN is defined.
module timer_dev #(
  parameter int WIDTH = 32,
  parameter int PS_W  = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic             ctrl_wr;
  logic             preset_wr;
  logic             en_w;
  logic             reload;
  logic             ps_tick;
  logic [WIDTH-1:0] ctrl_rd;

`ifdef TIMER_PRESCALE_EN
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [PS_W-1:0]  ps_cnt_q, ps_cnt_d;

  // The prescale counter only runs while counting; LOAD and IDLE (and aborts) clear it.
  always_comb begin
    ps_d     = ctrl_wr ? DIN[8 +: PS_W] : ps_q;
    ps_tick  = (ps_cnt_q == ps_q);
    ps_cnt_d = '0;
    if (state_q == S_CNT && en_w && !ps_tick) begin
      ps_cnt_d = ps_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ps_q     <= '0;
      ps_cnt_q <= '0;
    end else begin
      ps_q     <= ps_d;
      ps_cnt_q <= ps_cnt_d;
    end
  end
`else
  assign ps_tick = 1'b1;
`endif

  always_comb begin
    ctrl_wr   = WE && (Addr == ADDR_CTRL);
    preset_wr = WE && (Addr == ADDR_PRESET);

    en_w      = ctrl_wr ? DIN[0]   : en_q;
    en_d      = en_w;
    mode_d    = ctrl_wr ? DIN[2:1] : mode_q;
    im_d      = ctrl_wr ? DIN[3]   : im_q;
    preset_d  = preset_wr ? DIN : preset_q;
    reload    = (mode_d == 2'd1);

    // Any CTRL write clears pend; a terminal count below overrides it (set wins).
    pend_d    = ctrl_wr ? 1'b0 : pend_q;
    count_d   = count_q;
    state_d   = state_q;

    if (state_q != S_IDLE && !en_w) begin
      // Disabling mid-run drops straight to IDLE, freezing COUNT without raising pend.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Start one edge after EN is registered, so IRQ lands at edge PRESET+2.
          if (en_q && en_w) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          count_d = preset_q;
          state_d = S_CNT;
        end
        S_CNT: begin
          if (ps_tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - 1'b1;
            end else begin
              count_d = '0;
              pend_d  = 1'b1;
              state_d = S_INT;
            end
          end
        end
        S_INT: begin
          if (reload) begin
            pend_d  = 1'b0;
            state_d = S_LOAD;
          end else begin
            en_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ctrl_rd      = '0;
    ctrl_rd[0]   = en_q;
    ctrl_rd[2:1] = mode_q;
    ctrl_rd[3]   = im_q;
`ifdef TIMER_PRESCALE_EN
    ctrl_rd[8 +: PS_W] = ps_q;
`endif
  end

  always_comb begin
    DOUT = '0;
    unique case (Addr)
      ADDR_CTRL:   DOUT = ctrl_rd;
      ADDR_PRESET: DOUT = preset_q;
      ADDR_COUNT:  DOUT = count_q;
      default:     DOUT = '0;
    endcase
  end

  // Combinational so that an asynchronous reset drops IRQ immediately.
  assign IRQ = im_q & pend_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev (default build, no prescaler).
module tb_timer_dev;

  logic        Clk;
  logic        Reset_n;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  timer_dev #(.WIDTH(32), .PS_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .WE(WE),
    .DIN(DIN), .DOUT(DOUT), .IRQ(IRQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; DIN = d; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = DOUT;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        exp_irq;

    tbl[0] = '{1'b1, 2'd1, 32'h0000_1234, 2'd1, 32'h0000_1234};
    tbl[1] = '{1'b1, 2'd2, 32'h0000_0055, 2'd2, 32'h0000_0000};
    tbl[2] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    tbl[3] = '{1'b1, 2'd0, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006};
    tbl[4] = '{1'b1, 2'd0, 32'h0000_0008, 2'd0, 32'h0000_0008};
    tbl[5] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF};
    tbl[6] = '{1'b0, 2'd1, 32'h0000_0000, 2'd2, 32'h0000_0000};
    tbl[7] = '{1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};

    // Reset with bus activity
    Reset_n = 1'b0; WE = 1'b1; Addr = 2'd0; DIN = 32'hFFFF_FFFF;
    repeat (2) tick();
    WE = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check("reset_dout", v, 32'h0);
    end
    check("reset_irq", IRQ, 1'b0);
    Reset_n = 1'b1;
    tick();

    // Register access table
    for (int i = 0; i < 8; i++) begin
      Addr = tbl[i].addr; DIN = tbl[i].din; WE = tbl[i].we;
      tick();
      WE = 1'b0;
      rd(tbl[i].raddr, v);
      check("reg_table", v, tbl[i].exp_dout);
      check("reg_table_irq", IRQ, 1'b0);
    end

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      tick();
      rd(2'd2, v);
      check("oneshot_count", v, (k < 2) ? 32'd0 : (k <= 6 ? 32'(7 - k) : 32'd0));
      check("oneshot_irq", IRQ, (k >= 7));
    end
    rd(2'd0, v);
    check("oneshot_en_cleared", v, 32'h8);
    wr(2'd0, 32'h8);
    check("oneshot_irq_cleared", IRQ, 1'b0);
    tick();
    check("oneshot_irq_stays_low", IRQ, 1'b0);

    // Masked interrupt, PRESET=4, IM=0
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("masked_irq", IRQ, 1'b0);
    end
    rd(2'd0, v);
    check("masked_en_cleared", v, 32'h0);
    wr(2'd0, 32'h8);
    check("masked_unmask_irq", IRQ, 1'b0);
    tick();
    check("masked_unmask_irq2", IRQ, 1'b0);

    // PRESET=0 behaves as PRESET=1
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("p0_irq", IRQ, (k == 3));
    end

    // CTRL rewrite on the terminal edge: set beats clear, no restart
    wr(2'd0, 32'h0);
    check("p0_clear", IRQ, 1'b0);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("setwins_pre_irq", IRQ, 1'b0);
    end
    wr(2'd0, 32'h9);
    check("setwins_irq", IRQ, 1'b1);
    tick();
    check("setwins_hold", IRQ, 1'b1);

    // Auto-reload PRESET=3, retune to 6, then abort with COUNT=2
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 48; k++) begin
      if (k == 18) begin
        Addr = 2'd1; DIN = 32'd6; WE = 1'b1;
      end
      if (k == 43) begin
        Addr = 2'd0; DIN = 32'd0; WE = 1'b1;
      end
      tick();
      WE = 1'b0;
      exp_irq = (k == 5) || (k == 10) || (k == 15) || (k == 20) || (k == 28) || (k == 36);
      check("reload_irq", IRQ, exp_irq);
      if (k >= 42) begin
        rd(2'd2, v);
        check("abort_count_hold", v, 32'd2);
      end
    end

    // Asynchronous reset mid-run
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    repeat (5) tick();
    check("midreset_irq_before", IRQ, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    check("midreset_irq_async", IRQ, 1'b0);
    rd(2'd0, v);
    check("midreset_ctrl", v, 32'h0);
    rd(2'd1, v);
    check("midreset_preset", v, 32'h0);
    rd(2'd2, v);
    check("midreset_count", v, 32'h0);
    Reset_n = 1'b1;
    repeat (3) tick();
    check("postreset_irq", IRQ, 1'b0);
    rd(2'd2, v);
    check("postreset_count", v, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
